intc_scheduler: RTL and testbench

//   Sequences interrupt delivery between N accelerator "done" sources and the CPU.
//   - Edge-detects and latches requests; applies a per-source mask; picks one winner.
//   - Runs the IRQ/IACK/EOI handshake with the CPU, one interrupt at a time (no nesting).
//   - Presents that source's vector address to the CPU.

---
 rtl/intc_sched_pkg.sv | 18 +
 rtl/intc_arbiter.sv | 41 ++++
 rtl/intc_scheduler.sv | 131 +++++++++++++
 tb/tb_intc_scheduler.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/intc_sched_pkg.sv
// Shared encodings and helpers for the interrupt scheduler.
// The state encoding and vector-address arithmetic live here.
package intc_sched_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] SVC  = 2'd2;

  // Callers truncate the result to their own address width.
  function automatic logic [63:0] vec_addr(
    input logic [63:0] base,
    input logic [63:0] stride,
    input logic [3:0]  sel
  );
    return base + stride * {60'd0, sel};
  endfunction

endpackage

// File: rtl/intc_arbiter.sv
// Winner selection among eligible interrupt sources.
// INTC_SCHED_RR_EN selects round-robin; otherwise lowest index wins.
module intc_arbiter #(
  parameter  int N  = 4,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [SW-1:0] rr_ptr,
  output logic [SW-1:0] sel,
  output logic          any
);

`ifdef INTC_SCHED_RR_EN
  // Scan downward so the lowest offset from rr_ptr is written last.
  always_comb begin
    sel = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (eligible[(int'(rr_ptr) + k) % N]) begin
        sel = SW'((int'(rr_ptr) + k) % N);
        any = 1'b1;
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^rr_ptr;

  always_comb begin
    sel = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (eligible[k]) begin
        sel = SW'(k);
        any = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/intc_scheduler.sv
// IRQ/IACK/EOI sequencer for N accelerator done sources.
// Define INTC_SCHED_RR_EN for round-robin arbitration.
module intc_scheduler
  import intc_sched_pkg::*;
#(
  parameter  int              N_SRC      = 4,
  parameter  int              ADDR_W     = 32,
  parameter  logic [ADDR_W-1:0] VEC_BASE   = '0,
  parameter  logic [ADDR_W-1:0] VEC_STRIDE = ADDR_W'(32'h20),
  localparam int              SW         = $clog2(N_SRC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_SRC-1:0]  done,
  input  logic              mask_we,
  input  logic [N_SRC-1:0]  mask_wdata,
  input  logic              iack,
  input  logic              eoi,
  output logic              irq,
  output logic [ADDR_W-1:0] addr,
  output logic [N_SRC-1:0]  pending,
  output logic [N_SRC-1:0]  in_service,
  output logic [N_SRC-1:0]  mask,
  output logic [N_SRC-1:0]  overrun
);

  logic [1:0]        state_q;
  logic [SW-1:0]     sel_q;
  logic              irq_q;
  logic [ADDR_W-1:0] addr_q;
  logic [N_SRC-1:0]  done_q;
  logic [N_SRC-1:0]  pending_q, pending_d;
  logic [N_SRC-1:0]  overrun_q, overrun_d;
  logic [N_SRC-1:0]  mask_q;
  logic [N_SRC-1:0]  insvc_q;
  logic [N_SRC-1:0]  edge_w;
  logic [N_SRC-1:0]  eligible;
  logic [SW-1:0]     win;
  logic [SW-1:0]     rr_ptr;
  logic              any;
  logic              ack;
  logic [ADDR_W-1:0] vec_a;

  assign edge_w   = done & ~done_q;
  assign eligible = pending_q & ~mask_q;
  assign ack      = (state_q == REQ) && iack;
  assign vec_a    = ADDR_W'(vec_addr(64'(VEC_BASE), 64'(VEC_STRIDE), 4'(win)));

  // A fresh edge outranks the acknowledge clear of the same source.
  always_comb begin
    pending_d = pending_q;
    if (ack) pending_d[sel_q] = 1'b0;
    pending_d = pending_d | edge_w;
    overrun_d = overrun_q | (edge_w & pending_q);
  end

  intc_arbiter #(.N(N_SRC)) u_arb (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .sel      (win),
    .any      (any)
  );

`ifdef INTC_SCHED_RR_EN
  logic [SW-1:0] rr_ptr_q;
  assign rr_ptr = rr_ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else if (ack) begin
      rr_ptr_q <= (sel_q == SW'(N_SRC - 1)) ? '0 : sel_q + 1'b1;
    end
  end
`else
  assign rr_ptr = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      irq_q     <= 1'b0;
      addr_q    <= '0;
      done_q    <= '0;
      pending_q <= '0;
      overrun_q <= '0;
      mask_q    <= '0;
      insvc_q   <= '0;
    end else begin
      done_q    <= done;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      if (mask_we) mask_q <= mask_wdata;
      unique case (state_q)
        IDLE: begin
          if (any) begin
            sel_q   <= win;
            addr_q  <= vec_a;
            irq_q   <= 1'b1;
            state_q <= REQ;
          end else begin
            irq_q <= 1'b0;
          end
        end
        REQ: begin
          if (iack) begin
            insvc_q <= N_SRC'(1) << sel_q;
            irq_q   <= 1'b0;
            state_q <= SVC;
          end
        end
        SVC: begin
          if (eoi) begin
            insvc_q <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign irq        = irq_q;
  assign addr       = addr_q;
  assign pending    = pending_q;
  assign in_service = insvc_q;
  assign mask       = mask_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_intc_scheduler.sv
// Randomized bench for intc_scheduler with a behavioural reference.
// Directed literal checks pin the reference; define INTC_SCHED_RR_EN for RR.
module tb_intc_scheduler;

  localparam int N = 4;
`ifdef INTC_SCHED_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  done;
  logic        mask_we;
  logic [3:0]  mask_wdata;
  logic        iack;
  logic        eoi;
  logic        irq;
  logic [31:0] addr;
  logic [3:0]  pending;
  logic [3:0]  in_service;
  logic [3:0]  mask;
  logic [3:0]  overrun;

  always #5 clk = ~clk;

  intc_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .done       (done),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .iack       (iack),
    .eoi        (eoi),
    .irq        (irq),
    .addr       (addr),
    .pending    (pending),
    .in_service (in_service),
    .mask       (mask),
    .overrun    (overrun)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference state: sets of sources plus a three-phase handshake.
  logic [3:0]  m_prev, m_pend, m_ovr, m_msk, m_insvc;
  logic        m_irq;
  logic [31:0] m_addr;
  int          m_phase, m_cur, m_ptr;

  function automatic int pick(input logic [3:0] el, input int p);
    for (int k = 0; k < N; k++) begin
      if (el[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk) begin : model
    logic [3:0] e;
    logic [3:0] np;
    int w;
    if (rst) begin
      m_prev = '0; m_pend = '0; m_ovr = '0; m_msk = '0; m_insvc = '0;
      m_irq = 1'b0; m_addr = '0; m_phase = 0; m_cur = 0; m_ptr = 0;
    end else begin
      e  = done & ~m_prev;
      np = m_pend;
      case (m_phase)
        0: begin
          w = pick(m_pend & ~m_msk, RR ? m_ptr : 0);
          if (w >= 0) begin
            m_cur = w;
            m_irq = 1'b1;
            m_addr = 32'(w) * 32'h20;
            m_phase = 1;
          end else begin
            m_irq = 1'b0;
          end
        end
        1: if (iack) begin
          np[m_cur] = 1'b0;
          m_insvc = 4'b0001 << m_cur;
          m_irq = 1'b0;
          m_phase = 2;
          m_ptr = (m_cur + 1) % N;
        end
        default: if (eoi) begin
          m_insvc = '0;
          m_phase = 0;
        end
      endcase
      m_ovr  = m_ovr | (e & m_pend);
      m_pend = np | e;
      if (mask_we) m_msk = mask_wdata;
      m_prev = done;
    end
  end

  task automatic cmp(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("irq", 32'(irq), 32'(m_irq));
      cmp("addr", addr, m_addr);
      cmp("pending", 32'(pending), 32'(m_pend));
      cmp("in_service", 32'(in_service), 32'(m_insvc));
      cmp("mask", 32'(mask), 32'(m_msk));
      cmp("overrun", 32'(overrun), 32'(m_ovr));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_iack();
    iack = 1'b1; step(); iack = 1'b0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1; step(); eoi = 1'b0;
  endtask

  initial begin
    rst = 1'b1; done = '0; mask_we = 1'b0; mask_wdata = '0;
    iack = 1'b0; eoi = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    cmp("rst_irq", 32'(irq), 32'd0);
    cmp("rst_addr", addr, 32'd0);
    cmp("rst_pending", 32'(pending), 32'd0);
    rst = 1'b0;

    // single source 2
    done = 4'b0100; step();
    cmp("t1_pending", 32'(pending), 32'h4);
    cmp("t1_irq0", 32'(irq), 32'd0);
    done = '0; step();
    cmp("t1_irq", 32'(irq), 32'd1);
    cmp("t1_addr", addr, 32'h40);
    pulse_iack();
    cmp("t1_insvc", 32'(in_service), 32'h4);
    cmp("t1_pend0", 32'(pending), 32'h0);
    cmp("t1_irqlo", 32'(irq), 32'd0);
    pulse_eoi();
    step();

    // simultaneous sources 1 and 3
    done = 4'b1010; step();
    done = '0; step();
    cmp("t2_addr_a", addr, RR ? 32'h60 : 32'h20);
    pulse_iack();
    pulse_eoi();
    step();
    cmp("t2_irq_b", 32'(irq), 32'd1);
    cmp("t2_addr_b", addr, RR ? 32'h20 : 32'h60);
    pulse_iack();
    pulse_eoi();
    step();

    // masked source 0
    mask_we = 1'b1; mask_wdata = 4'b0001; step();
    mask_we = 1'b0; done = 4'b0001; step();
    done = '0; step();
    cmp("t3_pending", 32'(pending), 32'h1);
    cmp("t3_irq0", 32'(irq), 32'd0);
    step();
    cmp("t3_irq0b", 32'(irq), 32'd0);
    mask_we = 1'b1; mask_wdata = '0; step();
    mask_we = 1'b0; step();
    cmp("t3_irq", 32'(irq), 32'd1);
    cmp("t3_addr", addr, 32'h0);
    pulse_iack();
    pulse_eoi();
    step();

    // overrun on source 3
    done = 4'b1000; step();
    done = '0; step();
    done = 4'b1000; step();
    cmp("t4_overrun", 32'(overrun), 32'h8);
    done = '0; step();
    pulse_iack();
    cmp("t4_pend", 32'(pending), 32'h0);
    pulse_eoi();
    step();
    cmp("t4_irq_none", 32'(irq), 32'd0);
    cmp("t4_sticky", 32'(overrun), 32'h8);

    // ignored handshakes, edge racing iack
    pulse_iack();
    cmp("t5_idle_insvc", 32'(in_service), 32'h0);
    done = 4'b0010; step();
    done = '0; step();
    pulse_eoi();
    cmp("t5_req_irq", 32'(irq), 32'd1);
    cmp("t5_req_insvc", 32'(in_service), 32'h0);
    iack = 1'b1; done = 4'b0010; step();
    iack = 1'b0; done = '0;
    cmp("t5_pend_kept", 32'(pending), 32'h2);
    cmp("t5_insvc", 32'(in_service), 32'h2);
    pulse_eoi();
    step();
    cmp("t5_irq_again", 32'(irq), 32'd1);
    cmp("t5_addr", addr, 32'h20);
    pulse_iack();
    pulse_eoi();

    // reset in SVC with done[2] held
    done = 4'b0100; step();
    step();
    pulse_iack();
    cmp("t6_insvc", 32'(in_service), 32'h4);
    rst = 1'b1; step();
    cmp("t6_rst_insvc", 32'(in_service), 32'h0);
    cmp("t6_rst_ovr", 32'(overrun), 32'h0);
    cmp("t6_rst_irq", 32'(irq), 32'd0);
    rst = 1'b0; step();
    cmp("t6_pend", 32'(pending), 32'h4);
    step();
    cmp("t6_irq", 32'(irq), 32'd1);
    cmp("t6_addr", addr, 32'h40);
    done = '0;
    pulse_iack();
    pulse_eoi();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      done       = 4'($urandom);
      mask_we    = ($urandom_range(15) == 0);
      mask_wdata = 4'($urandom & $urandom);
      iack       = ($urandom_range(2) == 0);
      eoi        = ($urandom_range(2) == 0);
      rst        = ($urandom_range(299) == 0);
      step();
    end
    rst = 1'b0; iack = 1'b0; eoi = 1'b0; mask_we = 1'b0;
    step();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
